max_forwarding_param: RTL and testbench
=======================================

# max_forwarding_param

Parametrised group-max forwarder for the softmax-approximation datapath. Takes one local maximum per valid beat from the max-tree, folds consecutive beats of a group into a signed running maximum, and back-fills that group maximum into every beat of the group while the beats sit in a fixed-depth delay line. Payload and sideband travel alongside, so the downstream exp/subtract stage receives each beat together with its group's global max.

## Interface
- `DATA_W`, 16: width of the signed local/global max.
- `PAY_W`, 1024: payload (flattened input vector) width, bypassed unchanged.
- `SIDE_W`, 112: sideband width (packed sub-tree maxima), bypassed unchanged.
- `MAX_GRP`, 12: maximum group length in beats; also the pipeline depth.
- `LEN_W`, `$clog2(MAX_GRP+1)`: group-length field width.

Ports:
- `i_clk` in 1: clock.
- `i_rst` in 1: synchronous, active-high reset.
- `i_en` in 1: global advance; 0 freezes all state.
- `i_valid` in 1: beat valid.
- `i_loc_max` in DATA_W: signed local max of the beat.
- `i_grp_len` in LEN_W: beats per group; 0 or 1 means no grouping.
- `i_payload` in PAY_W: bypass data.
- `i_side` in SIDE_W: bypass sideband.
- `o_valid` out 1: delayed `i_valid`.
- `o_global_max` out DATA_W: group max, or local max for ungrouped or unfinished beats.
- `o_grp_len` out LEN_W: delayed effective (latched, clamped) group length.
- `o_last` out 1: marks the final beat of a completed group.
- `o_payload` out PAY_W: delayed payload.
- `o_side` out SIDE_W: delayed sideband.

## Operation
- `NEG_MIN` = 1 followed by DATA_W-1 zeros. All comparisons are signed.
- Effective length L:
  - Sampled from `i_grp_len` on the first beat of a group, when the counter is 0.
  - Held in a register until the group ends; `i_grp_len` is ignored mid-group.
  - Values above MAX_GRP clamp to MAX_GRP.
- Counter `cnt` (0..MAX_GRP-1) and accumulator `acc` (reset value NEG_MIN).
  - `front = max(acc, i_loc_max)`.
- Group end: `i_valid & L>=2 & cnt==L-1`.
- Delay line `mx[0..MAX_GRP-1]`, advanced when `i_en` is 1:
  - Default shift: `mx[0]<=i_loc_max`, `mx[k]<=mx[k-1]`.
  - On group end: stages 0..L-1 load `front`. This covers the incoming beat plus the L-1 beats already in flight. All other stages shift normally.
  - After a group end: `cnt<=0`, `acc<=NEG_MIN`.
- Valid grouped beat that is not an end: `cnt<=cnt+1`, `acc<=front`.
- Ungrouped valid beat (L<=1): `cnt=0`, `acc=NEG_MIN`. The beat passes through with its local max.
- Invalid beat with `cnt>0` (group broken): `cnt<=0`, `acc<=NEG_MIN`. Partial-group handling is set by the configuration macro.
- Parallel pipes of MAX_GRP stages carry valid, L, last-flag, payload and sideband.
- A new group may start on the cycle right after a group end. Back-to-back groups never share a stage write, because the load mask only covers the group's own stages.

## Timing
- Latency is exactly MAX_GRP enabled cycles from input beat to output beat, for all fields.
- `i_en=0` holds every register, including `cnt`, `acc` and L. Inputs are ignored that cycle.
- Reset values:
  - `o_global_max`: NEG_MIN (all `mx` stages).
  - `o_valid`, `o_last`, `o_grp_len`, `o_payload`, `o_side`: 0.
  - `cnt`: 0; `acc`: NEG_MIN.
- Reset mid-group discards all in-flight beats. Beats after reset start a fresh group.
- No backpressure. Throughput is one beat per enabled cycle.

## Configuration
- `MAX_FWD_PARTIAL_FLUSH_EN` defined: on a broken group (invalid beat with `cnt>0`), stages 1..cnt load `acc`. The partial beats leave carrying their partial-group max, with `o_last=0`.
- Not defined: partial beats keep their own local max.

## Test plan
- Ungrouped pass-through: L=1, beats 0x0005, 0xFFF0, 0x7FFF → after 12 cycles, outputs are the same values in order; `o_last=0` throughout.
- L=4 group: local maxes 0x0003, 0xFFFE (-2), 0x0010, 0x0001 → all four beats output 0x0010; `o_last` is high only on the fourth beat.
- Back-to-back groups with L=2: maxes {0x8001, 0x8002}, then {0x0007, 0x0002} → outputs 0x8002, 0x8002, 0x0007, 0x0007. No cross-contamination between groups.
- L=12 (full depth) with the max on beat 0: all 12 outputs equal beat 0's max. `i_grp_len=15` behaves identically (clamped to 12).
- Broken group with L=4: 3 beats {1, 9, 4}, then an invalid beat.
  - Macro off: outputs 1, 9, 4.
  - Macro on: outputs 9, 9, 9.
  - In both cases the next group starts cleanly.
- Stall and reset:
  - `i_en` low for 5 cycles in the middle of a group → the result equals the unstalled run, delayed by 5 cycles.
  - `i_rst` pulsed mid-group → outputs become 0, with `o_global_max`=0x8000, on the next cycle; the accumulator is cleared.

Source files
------------

// File: rtl/max_forwarding_param.sv
// Group-max forwarder: folds a signed running max over each beat group and back-fills it
// into the group's in-flight beats. Optional MAX_FWD_PARTIAL_FLUSH_EN back-fills broken groups too.
module max_forwarding_param #(
    parameter int DATA_W  = 16,
    parameter int PAY_W   = 1024,
    parameter int SIDE_W  = 112,
    parameter int MAX_GRP = 12,
    parameter int LEN_W   = $clog2(MAX_GRP + 1)
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_en,
    input  logic              i_valid,
    input  logic [DATA_W-1:0] i_loc_max,
    input  logic [LEN_W-1:0]  i_grp_len,
    input  logic [PAY_W-1:0]  i_payload,
    input  logic [SIDE_W-1:0] i_side,
    output logic              o_valid,
    output logic [DATA_W-1:0] o_global_max,
    output logic [LEN_W-1:0]  o_grp_len,
    output logic              o_last,
    output logic [PAY_W-1:0]  o_payload,
    output logic [SIDE_W-1:0] o_side
);

    localparam logic [DATA_W-1:0] NEG_MIN = {1'b1, {(DATA_W-1){1'b0}}};
    localparam logic [LEN_W-1:0]  MAX_LEN = LEN_W'(MAX_GRP);

    logic [DATA_W-1:0] mx_q [MAX_GRP];
    logic [DATA_W-1:0] mx_d [MAX_GRP];
    logic [LEN_W-1:0]  len_pipe_q [MAX_GRP];
    logic [PAY_W-1:0]  pay_q [MAX_GRP];
    logic [SIDE_W-1:0] side_q [MAX_GRP];
    logic [MAX_GRP-1:0] vld_q, last_q;

    logic [LEN_W-1:0]  cnt_q, cnt_d, len_q, len_eff;
    logic [DATA_W-1:0] acc_q, acc_d, front;
    logic              grp_end;

    // Group length is only sampled on the first beat; mid-group the latched value rules.
    always_comb begin
        len_eff = len_q;
        if (cnt_q == '0)
            len_eff = (i_grp_len > MAX_LEN) ? MAX_LEN : i_grp_len;
        front   = ($signed(i_loc_max) > $signed(acc_q)) ? i_loc_max : acc_q;
        grp_end = i_valid && (len_eff >= LEN_W'(2)) && (cnt_q == len_eff - LEN_W'(1));
    end

    always_comb begin
        cnt_d = cnt_q;
        acc_d = acc_q;
        if (grp_end) begin
            cnt_d = '0;
            acc_d = NEG_MIN;
        end else if (i_valid && (len_eff >= LEN_W'(2))) begin
            cnt_d = cnt_q + LEN_W'(1);
            acc_d = front;
        end else if (i_valid || (cnt_q != '0)) begin
            cnt_d = '0;
            acc_d = NEG_MIN;
        end
    end

    always_comb begin
        mx_d[0] = i_loc_max;
        for (int k = 1; k < MAX_GRP; k++)
            mx_d[k] = mx_q[k-1];
`ifdef MAX_FWD_PARTIAL_FLUSH_EN
        // Broken group: the cnt partial beats shift into stages 1..cnt, stamp them with acc.
        if (!i_valid && (cnt_q != '0)) begin
            for (int k = 1; k < MAX_GRP; k++)
                if (k <= int'(cnt_q))
                    mx_d[k] = acc_q;
        end
`endif
        // Group end: incoming beat plus the L-1 beats in flight land in stages 0..L-1.
        if (grp_end) begin
            for (int k = 0; k < MAX_GRP; k++)
                if (k < int'(len_eff))
                    mx_d[k] = front;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cnt_q  <= '0;
            acc_q  <= NEG_MIN;
            len_q  <= '0;
            vld_q  <= '0;
            last_q <= '0;
            for (int k = 0; k < MAX_GRP; k++) begin
                mx_q[k]       <= NEG_MIN;
                len_pipe_q[k] <= '0;
                pay_q[k]      <= '0;
                side_q[k]     <= '0;
            end
        end else if (i_en) begin
            cnt_q  <= cnt_d;
            acc_q  <= acc_d;
            len_q  <= len_eff;
            vld_q  <= {vld_q[MAX_GRP-2:0], i_valid};
            last_q <= {last_q[MAX_GRP-2:0], grp_end};
            mx_q   <= mx_d;
            len_pipe_q[0] <= len_eff;
            pay_q[0]      <= i_payload;
            side_q[0]     <= i_side;
            for (int k = 1; k < MAX_GRP; k++) begin
                len_pipe_q[k] <= len_pipe_q[k-1];
                pay_q[k]      <= pay_q[k-1];
                side_q[k]     <= side_q[k-1];
            end
        end
    end

    assign o_valid      = vld_q[MAX_GRP-1];
    assign o_last       = last_q[MAX_GRP-1];
    assign o_global_max = mx_q[MAX_GRP-1];
    assign o_grp_len    = len_pipe_q[MAX_GRP-1];
    assign o_payload    = pay_q[MAX_GRP-1];
    assign o_side       = side_q[MAX_GRP-1];

endmodule

// File: tb/tb_max_forwarding_param.sv
// Directed bench for max_forwarding_param; expectations follow MAX_FWD_PARTIAL_FLUSH_EN when defined.
module tb_max_forwarding_param;

    localparam int DW = 16, PW = 1024, SW = 112, MG = 12, LW = 4;

    logic          i_clk = 1'b0;
    logic          i_rst, i_en, i_valid;
    logic [DW-1:0] i_loc_max;
    logic [LW-1:0] i_grp_len;
    logic [PW-1:0] i_payload;
    logic [SW-1:0] i_side;
    logic          o_valid, o_last;
    logic [DW-1:0] o_global_max;
    logic [LW-1:0] o_grp_len;
    logic [PW-1:0] o_payload;
    logic [SW-1:0] o_side;

    max_forwarding_param #(.DATA_W(DW), .PAY_W(PW), .SIDE_W(SW), .MAX_GRP(MG), .LEN_W(LW)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_en(i_en), .i_valid(i_valid),
        .i_loc_max(i_loc_max), .i_grp_len(i_grp_len), .i_payload(i_payload), .i_side(i_side),
        .o_valid(o_valid), .o_global_max(o_global_max), .o_grp_len(o_grp_len),
        .o_last(o_last), .o_payload(o_payload), .o_side(o_side)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [15:0] gm;
        logic        last;
        logic [3:0]  len;
        logic [15:0] pay;
        logic        pay_ok;
        logic        side_ok;
        int          cyc;
    } ent_t;

    ent_t log_q[$];
    int   checks = 0, errors = 0, cyc = 0;
    logic en_s = 1'b0;

    always @(posedge i_clk) begin
        cyc  <= cyc + 1;
        en_s <= i_en & ~i_rst;
    end

    // Log each output beat once per enabled edge.
    always @(negedge i_clk) begin
        ent_t e;
        if (en_s && o_valid) begin
            e.gm      = o_global_max;
            e.last    = o_last;
            e.len     = o_grp_len;
            e.pay     = o_payload[15:0];
            e.pay_ok  = (o_payload === {64{o_payload[15:0]}});
            e.side_ok = (o_side === {7{~o_payload[15:0]}});
            e.cyc     = cyc;
            log_q.push_back(e);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_beat(input int idx, input logic [15:0] gm, input logic [15:0] lm,
                            input logic last, input logic [3:0] len);
        string t;
        logic  present;
        t = $sformatf("beat%0d", idx);
        present = (idx < log_q.size());
        chk({t, ".present"}, 32'(present), 32'd1);
        if (present) begin
            chk({t, ".gmax"}, 32'(log_q[idx].gm), 32'(gm));
            chk({t, ".last"}, 32'(log_q[idx].last), 32'(last));
            chk({t, ".len"},  32'(log_q[idx].len), 32'(len));
            chk({t, ".pay"},  32'(log_q[idx].pay), 32'(lm));
            chk({t, ".payw"}, 32'(log_q[idx].pay_ok & log_q[idx].side_ok), 32'd1);
        end
    endtask

    task automatic drive(input logic v, input logic [15:0] m, input logic [3:0] len);
        i_valid   = v;
        i_loc_max = m;
        i_grp_len = len;
        i_payload = {64{m}};
        i_side    = {7{~m}};
        @(posedge i_clk); #1;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 16'h0, 4'd0);
    endtask

    int base, t0, t3;

    initial begin
        i_rst = 1'b1; i_en = 1'b1; i_valid = 1'b0; i_loc_max = '0; i_grp_len = '0;
        i_payload = '0; i_side = '0;
        repeat (2) @(posedge i_clk);
        #1;
        chk("rst.valid", 32'(o_valid), 32'd0);
        chk("rst.gmax",  32'(o_global_max), 32'h8000);
        chk("rst.last",  32'(o_last), 32'd0);
        chk("rst.len",   32'(o_grp_len), 32'd0);
        chk("rst.pay",   32'(|o_payload | |o_side), 32'd0);
        i_rst = 1'b0;

        // Ungrouped pass-through
        base = log_q.size(); t0 = cyc;
        drive(1, 16'h0005, 1); drive(1, 16'hFFF0, 1); drive(1, 16'h7FFF, 1);
        idle(13);
        chk("ungrp.count", 32'(log_q.size() - base), 32'd3);
        chk_beat(base + 0, 16'h0005, 16'h0005, 0, 1);
        chk_beat(base + 1, 16'hFFF0, 16'hFFF0, 0, 1);
        chk_beat(base + 2, 16'h7FFF, 16'h7FFF, 0, 1);
        if (log_q.size() > base) chk("ungrp.latency", 32'(log_q[base].cyc - t0), 32'd12);

        // L=4 group
        base = log_q.size();
        drive(1, 16'h0003, 4); drive(1, 16'hFFFE, 4); drive(1, 16'h0010, 4); drive(1, 16'h0001, 4);
        idle(13);
        chk("l4.count", 32'(log_q.size() - base), 32'd4);
        chk_beat(base + 0, 16'h0010, 16'h0003, 0, 4);
        chk_beat(base + 1, 16'h0010, 16'hFFFE, 0, 4);
        chk_beat(base + 2, 16'h0010, 16'h0010, 0, 4);
        chk_beat(base + 3, 16'h0010, 16'h0001, 1, 4);

        // Back-to-back L=2 groups
        base = log_q.size();
        drive(1, 16'h8001, 2); drive(1, 16'h8002, 2); drive(1, 16'h0007, 2); drive(1, 16'h0002, 2);
        idle(13);
        chk("b2b.count", 32'(log_q.size() - base), 32'd4);
        chk_beat(base + 0, 16'h8002, 16'h8001, 0, 2);
        chk_beat(base + 1, 16'h8002, 16'h8002, 1, 2);
        chk_beat(base + 2, 16'h0007, 16'h0007, 0, 2);
        chk_beat(base + 3, 16'h0007, 16'h0002, 1, 2);

        // Full depth L=12, then clamped L=15 straight after
        base = log_q.size();
        drive(1, 16'h0100, 12);
        for (int k = 1; k < 12; k++) drive(1, 16'(k), 12);
        drive(1, 16'h0200, 15);
        for (int k = 1; k < 12; k++) drive(1, 16'h0100 + 16'(k), 15);
        idle(13);
        chk("full.count", 32'(log_q.size() - base), 32'd24);
        chk_beat(base + 0,  16'h0100, 16'h0100, 0, 12);
        chk_beat(base + 5,  16'h0100, 16'h0005, 0, 12);
        chk_beat(base + 11, 16'h0100, 16'h000B, 1, 12);
        chk_beat(base + 12, 16'h0200, 16'h0200, 0, 12);
        chk_beat(base + 18, 16'h0200, 16'h0106, 0, 12);
        chk_beat(base + 23, 16'h0200, 16'h010B, 1, 12);

        // Broken L=4 group, then a clean L=2 group
        base = log_q.size();
        drive(1, 16'h0001, 4); drive(1, 16'h0009, 4); drive(1, 16'h0004, 4);
        idle(1);
        drive(1, 16'h0002, 2); drive(1, 16'h0003, 2);
        idle(13);
        chk("brk.count", 32'(log_q.size() - base), 32'd5);
`ifdef MAX_FWD_PARTIAL_FLUSH_EN
        chk_beat(base + 0, 16'h0009, 16'h0001, 0, 4);
        chk_beat(base + 1, 16'h0009, 16'h0009, 0, 4);
        chk_beat(base + 2, 16'h0009, 16'h0004, 0, 4);
`else
        chk_beat(base + 0, 16'h0001, 16'h0001, 0, 4);
        chk_beat(base + 1, 16'h0009, 16'h0009, 0, 4);
        chk_beat(base + 2, 16'h0004, 16'h0004, 0, 4);
`endif
        chk_beat(base + 3, 16'h0003, 16'h0002, 0, 2);
        chk_beat(base + 4, 16'h0003, 16'h0003, 1, 2);

        // Stall of 5 cycles mid-group; stalled-cycle inputs must be ignored
        base = log_q.size(); t0 = cyc;
        drive(1, 16'h0003, 4); drive(1, 16'hFFFE, 4);
        i_en = 1'b0;
        repeat (5) drive(1, 16'h7FFF, 2);
        i_en = 1'b1;
        drive(1, 16'h0010, 4);
        t3 = cyc;
        drive(1, 16'h0001, 4);
        idle(13);
        chk("stall.count", 32'(log_q.size() - base), 32'd4);
        chk_beat(base + 0, 16'h0010, 16'h0003, 0, 4);
        chk_beat(base + 1, 16'h0010, 16'hFFFE, 0, 4);
        chk_beat(base + 2, 16'h0010, 16'h0010, 0, 4);
        chk_beat(base + 3, 16'h0010, 16'h0001, 1, 4);
        if (log_q.size() > base + 3) begin
            chk("stall.lat_first", 32'(log_q[base].cyc - t0), 32'd17);
            chk("stall.lat_last",  32'(log_q[base + 3].cyc - t3), 32'd12);
        end

        // Reset mid-group
        for (int k = 0; k < 10; k++) drive(1, 16'h000A, 1);
        drive(1, 16'h0050, 4); drive(1, 16'h0060, 4);
        chk("prerst.valid", 32'(o_valid), 32'd1);
        chk("prerst.gmax",  32'(o_global_max), 32'h000A);
        i_rst = 1'b1;
        drive(0, 16'h0, 0);
        chk("midrst.valid", 32'(o_valid), 32'd0);
        chk("midrst.gmax",  32'(o_global_max), 32'h8000);
        chk("midrst.last",  32'(o_last), 32'd0);
        chk("midrst.len",   32'(o_grp_len), 32'd0);
        chk("midrst.pay",   32'(|o_payload | |o_side), 32'd0);
        i_rst = 1'b0;
        base = log_q.size();
        drive(1, 16'h0004, 2); drive(1, 16'h0002, 2);
        idle(13);
        chk("postrst.count", 32'(log_q.size() - base), 32'd2);
        chk_beat(base + 0, 16'h0004, 16'h0004, 0, 2);
        chk_beat(base + 1, 16'h0004, 16'h0002, 1, 2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
